// File: rtl/pq_pkg.sv
// Shared priority-queue types: default widths, sentinel key/value constants, op encoding.
// Optional replace operation is controlled by the PQ_REPLACE_EN macro in pq_shift_array.
package pq_pkg;

    localparam int PQ_KEY_WIDTH = 4;
    localparam int PQ_VAL_WIDTH = 4;
    localparam int PQ_CAPACITY  = 15;

    localparam logic [PQ_KEY_WIDTH-1:0] KEYINF = '1;
    localparam logic [PQ_KEY_WIDTH-1:0] KEY0   = '0;
    localparam logic [PQ_VAL_WIDTH-1:0] VAL0   = '0;
    localparam logic [PQ_KEY_WIDTH+PQ_VAL_WIDTH-1:0] KV_EMPTY = {KEYINF, VAL0};

    typedef enum logic [1:0] {
        PQ_NOP  = 2'd0,
        PQ_ENQ  = 2'd1,
        PQ_DEQ  = 2'd2,
        PQ_REPL = 2'd3
    } pq_op_t;

endpackage

// File: rtl/pq_slot.sv
// One sorted-array slot (valid + {key,value}); next state chosen from self, left or right neighbour, or kvi.
// Latency: one cycle. No backpressure; legality of op is decided by the parent.
module pq_slot
    import pq_pkg::*;
#(
    parameter int KW    = 4,
    parameter int VW    = 4,
    parameter bit FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  pq_op_t         op,
    input  logic [KW+VW-1:0] kvi,
    input  logic           left_vld,
    input  logic           left_flag,
    input  logic [KW+VW-1:0] left_kv,
    input  logic           right_vld,
    input  logic           right_flag,
    input  logic [KW+VW-1:0] right_kv,
    output logic           vld,
    output logic [KW+VW-1:0] kv,
    output logic           flag
);

    logic           nxt_vld;
    logic [KW+VW-1:0] nxt_kv;

    // "<=" keeps ties FIFO: the new entry lands after every equal key.
    assign flag = vld && (kv[KW+VW-1:VW] <= kvi[KW+VW-1:VW]);

    always_comb begin
        nxt_vld = vld;
        nxt_kv  = kv;
        case (op)
            PQ_ENQ: begin
                if (!flag) begin
                    if (left_flag) begin
                        nxt_vld = 1'b1;
                        nxt_kv  = kvi;
                    end else begin
                        nxt_vld = left_vld;
                        nxt_kv  = left_kv;
                    end
                end
            end
            PQ_DEQ: begin
                nxt_vld = right_vld;
                nxt_kv  = right_kv;
            end
            PQ_REPL: begin
                if (right_flag) begin
                    nxt_vld = right_vld;
                    nxt_kv  = right_kv;
                end else if (FIRST || flag) begin
                    nxt_vld = 1'b1;
                    nxt_kv  = kvi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            kv  <= {{KW{1'b1}}, {VW{1'b0}}};
        end else begin
            vld <= nxt_vld;
            kv  <= nxt_kv;
        end
    end

endmodule

// File: rtl/pq_shift_array.sv
// Shift-register priority queue, min key at head; one-cycle enq/deq, registered head, sticky err.
// Latency: op in cycle n visible after edge n+1. No handshake: full/empty are the flow control. Macro: PQ_REPLACE_EN.
module pq_shift_array
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = PQ_KEY_WIDTH,
    parameter int VAL_WIDTH = PQ_VAL_WIDTH,
    parameter int CAPACITY  = PQ_CAPACITY,
    localparam int CNT_W    = $clog2(CAPACITY + 1),
    localparam int KVW      = KEY_WIDTH + VAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [KVW-1:0]   kvi,
    output logic [KVW-1:0]   kvo,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [KVW-1:0] KV_NONE = {{KEY_WIDTH{1'b1}}, {VAL_WIDTH{1'b0}}};

    // Index CAPACITY is a permanently empty sentinel to the right of the last slot.
    logic [CAPACITY:0] vld_a;
    logic [CAPACITY:0] flag_a;
    logic [KVW-1:0]    kv_a [CAPACITY+1];
    pq_op_t            op;
    logic              bad;

    assign vld_a[CAPACITY]  = 1'b0;
    assign flag_a[CAPACITY] = 1'b0;
    assign kv_a[CAPACITY]   = KV_NONE;

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);
    assign kvo   = kv_a[0];

    always_comb begin
        op  = PQ_NOP;
        bad = 1'b0;
        case ({enq, deq})
            2'b10: if (full)  bad = 1'b1; else op = PQ_ENQ;
            2'b01: if (empty) bad = 1'b1; else op = PQ_DEQ;
            2'b11: begin
`ifdef PQ_REPLACE_EN
                if (empty) begin
                    op  = PQ_ENQ;
                    bad = 1'b1;
                end else begin
                    op  = PQ_REPL;
                end
`else
                bad = 1'b1;
                if (!empty) op = PQ_DEQ;
`endif
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < CAPACITY; i++) begin : g_slot
        logic           l_vld;
        logic           l_flag;
        logic [KVW-1:0] l_kv;

        // Slot 0 sees a virtual left neighbour whose flag is always set.
        if (i == 0) begin : g_head
            assign l_vld  = 1'b0;
            assign l_flag = 1'b1;
            assign l_kv   = KV_NONE;
        end else begin : g_body
            assign l_vld  = vld_a[i-1];
            assign l_flag = flag_a[i-1];
            assign l_kv   = kv_a[i-1];
        end

        pq_slot #(
            .KW    (KEY_WIDTH),
            .VW    (VAL_WIDTH),
            .FIRST (i == 0)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .op         (op),
            .kvi        (kvi),
            .left_vld   (l_vld),
            .left_flag  (l_flag),
            .left_kv    (l_kv),
            .right_vld  (vld_a[i+1]),
            .right_flag (flag_a[i+1]),
            .right_kv   (kv_a[i+1]),
            .vld        (vld_a[i]),
            .kv         (kv_a[i]),
            .flag       (flag_a[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (op == PQ_ENQ)      count <= count + 1'b1;
            else if (op == PQ_DEQ) count <= count - 1'b1;
            if (bad) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pq_shift_array.sv
// Directed bench for pq_shift_array: stimulus pushes expected post-edge state, a negedge monitor pops and compares.
module tb_pq_shift_array;
    import pq_pkg::*;

`ifdef PQ_REPLACE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enq;
    logic       deq;
    logic [7:0] kvi;
    logic [7:0] kvo;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        string      name;
        int         cnt;
        bit         er;
        logic [7:0] kv;
    } exp_t;

    exp_t q[$];

    pq_shift_array dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .kvi   (kvi),
        .kvo   (kvo),
        .full  (full),
        .empty (empty),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, expv);
        end
    endtask

    task automatic check_state(input string n, input int ecnt, input bit eerr, input logic [7:0] ekv);
        check({n, ".count"}, int'(count), ecnt);
        check({n, ".empty"}, int'(empty), int'(ecnt == 0));
        check({n, ".full"},  int'(full),  int'(ecnt == 15));
        check({n, ".err"},   int'(err),   int'(eerr));
        check({n, ".kvo"},   int'(kvo),   int'(ekv));
    endtask

    // Monitor: compares every expectation whose edge has passed.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check_state(e.name, e.cnt, e.er, e.kv);
        end
    end

    task automatic op(input bit e, input bit d, input logic [7:0] k,
                      input int ecnt, input bit eerr, input logic [7:0] ekv, input string n);
        @(negedge clk);
        #1;
        enq = e;
        deq = d;
        kvi = k;
        q.push_back('{cyc + 1, n, ecnt, eerr, ekv});
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
    endtask

    task automatic do_reset(input string n);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state(n, 0, 1'b0, KV_EMPTY);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit sticky;
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = 8'h00;
        #12;
        check_state("reset", 0, 1'b0, KV_EMPTY);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Sorting
        op(1, 0, 8'h7A, 1, 0, 8'h7A, "sort_enq7");
        op(1, 0, 8'h3B, 2, 0, 8'h3B, "sort_enq3");
        op(1, 0, 8'h9C, 3, 0, 8'h3B, "sort_enq9");
        op(1, 0, 8'h1D, 4, 0, 8'h1D, "sort_enq1");
        op(0, 1, 8'h00, 3, 0, 8'h3B, "sort_deq1");
        op(0, 1, 8'h00, 2, 0, 8'h7A, "sort_deq2");
        op(0, 1, 8'h00, 1, 0, 8'h9C, "sort_deq3");
        op(0, 1, 8'h00, 0, 0, KV_EMPTY, "sort_deq4");

        // Equal keys leave in arrival order
        op(1, 0, 8'h51, 1, 0, 8'h51, "tie_enq1");
        op(1, 0, 8'h52, 2, 0, 8'h51, "tie_enq2");
        op(1, 0, 8'h53, 3, 0, 8'h51, "tie_enq3");
        op(0, 1, 8'h00, 2, 0, 8'h52, "tie_deq1");
        op(0, 1, 8'h00, 1, 0, 8'h53, "tie_deq2");
        op(0, 1, 8'h00, 0, 0, KV_EMPTY, "tie_deq3");

        // Simultaneous enq+deq on {2,4,6}
        op(1, 0, 8'h21, 1, 0, 8'h21, "sim_enq2");
        op(1, 0, 8'h41, 2, 0, 8'h21, "sim_enq4");
        op(1, 0, 8'h61, 3, 0, 8'h21, "sim_enq6");
        sticky = !REPL;
        op(1, 1, 8'h57, REPL ? 3 : 2, sticky, 8'h41, "sim_both");
        if (REPL) begin
            op(0, 1, 8'h00, 2, sticky, 8'h57, "sim_deq5");
        end
        op(0, 1, 8'h00, 1, sticky, 8'h61, "sim_deq_a");
        op(0, 1, 8'h00, 0, sticky, KV_EMPTY, "sim_deq_b");

        // Reset mid-run with five entries
        for (int i = 1; i <= 5; i++) begin
            logic [3:0] k4;
            k4 = i[3:0];
            op(1, 0, {k4, k4}, i, sticky, 8'h11, "rst_fill");
        end
        do_reset("rst_mid");

        // Underflow and all-ones keys
        op(0, 1, 8'h00, 0, 1, KV_EMPTY, "unf_deq");
        op(1, 0, 8'hF4, 1, 1, 8'hF4, "ones_enq4");
        op(1, 0, 8'hF7, 2, 1, 8'hF4, "ones_enq7");
        op(0, 1, 8'h00, 1, 1, 8'hF7, "ones_deq4");
        op(0, 1, 8'h00, 0, 1, KV_EMPTY, "ones_deq7");
        do_reset("rst_clr");

        // Fill to capacity, then overflow
        for (int i = 15; i >= 1; i--) begin
            logic [3:0] k4;
            k4 = i[3:0];
            op(1, 0, {k4, 4'h5}, 16 - i, 0, {k4, 4'h5}, "ovf_fill");
        end
        op(1, 0, 8'h0F, 15, 1, 8'h15, "ovf_drop");
        op(0, 1, 8'h00, 14, 1, 8'h25, "ovf_deq");
        op(1, 0, 8'h0F, 15, 1, 8'h0F, "ovf_refill");
        op(1, 1, 8'h38, REPL ? 15 : 14, 1, 8'h25, "full_both");

        repeat (3) @(negedge clk);
        check("sb_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
